// File: rtl/redmule_mx_output_demux.sv
// Output demux for the engine Z stream: one registered stage that steers beats either to the
// Z streamer (FP16 bypass) or to the MX encoder, framing encoder beats into blocks.
module redmule_mx_output_demux #(
    parameter int unsigned DATAW_ALIGN  = 512,
    parameter int unsigned BITW         = 16,
    parameter int unsigned MX_NUM_LANES = 32,
    parameter int unsigned BLOCK_BEATS  = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           start_i,
    input  logic                           mx_enable_i,
    input  logic [CNT_W-1:0]               tot_beats_i,
    output logic                           busy_o,
    output logic                           done_o,
    // engine Z result stream
    input  logic                           z_valid_i,
    output logic                           z_ready_o,
    input  logic [DATAW_ALIGN-1:0]         z_data_i,
    input  logic [DATAW_ALIGN/8-1:0]       z_strb_i,
    // FP16 bypass towards the Z streamer
    output logic                           z_raw_valid_o,
    input  logic                           z_raw_ready_i,
    output logic [DATAW_ALIGN-1:0]         z_raw_data_o,
    output logic [DATAW_ALIGN/8-1:0]       z_raw_strb_o,
    // MX encoder beat interface
    output logic                           z_enc_valid_o,
    input  logic                           z_enc_ready_i,
    output logic [MX_NUM_LANES*BITW-1:0]   z_enc_data_o,
    output logic                           z_enc_last_o
);

    localparam int unsigned STRBW = DATAW_ALIGN / 8;
    localparam int unsigned ENCW  = MX_NUM_LANES * BITW;
    localparam int unsigned BLK_W = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic               mode_q;
    logic [CNT_W-1:0]   tot_q;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [BLK_W-1:0]   blk_cnt_q;
    logic               done_q;

    logic               buf_vld_q, buf_vld_d;
    logic [DATAW_ALIGN-1:0] buf_data_q, buf_data_d;
    logic [STRBW-1:0]   buf_strb_q, buf_strb_d;

    logic               out_ready;
    logic               out_hs;
    logic               in_ready;
    logic               in_hs;
    logic               blk_end;
    logic               job_last_beat;
    logic               job_end;

    // Handshake qualification: the only backward combinational path is out_ready into in_ready.
    always_comb begin
        out_ready     = mode_q ? z_enc_ready_i : z_raw_ready_i;
        out_hs        = buf_vld_q & out_ready;
        in_ready      = (state_q == RUN) & (in_cnt_q < tot_q) & (~buf_vld_q | out_ready);
        in_hs         = z_valid_i & in_ready;
        blk_end       = (blk_cnt_q == BLK_LAST);
        job_last_beat = (out_cnt_q == (tot_q - CNT_W'(1)));
        job_end       = out_hs & job_last_beat;
    end

    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_data_d = buf_data_q;
        buf_strb_d = buf_strb_q;
        if (clear_i) begin
            buf_vld_d = 1'b0;
        end else if (in_hs) begin
            // a reload on a simultaneous drain keeps the stage full
            buf_vld_d  = 1'b1;
            buf_data_d = z_data_i;
            buf_strb_d = z_strb_i;
        end else if (out_hs) begin
            buf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_vld_q  <= 1'b0;
            buf_data_q <= '0;
            buf_strb_q <= '0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_data_q <= buf_data_d;
            buf_strb_q <= buf_strb_d;
        end
    end

    // Job control: mode and length are latched only on an accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            tot_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            blk_cnt_q <= '0;
            done_q    <= 1'b0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            tot_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            blk_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q    <= mx_enable_i;
                        tot_q     <= tot_beats_i;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        blk_cnt_q <= '0;
                        if (tot_beats_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        in_cnt_q <= in_cnt_q + CNT_W'(1);
                    end
                    if (out_hs) begin
                        out_cnt_q <= out_cnt_q + CNT_W'(1);
                    end
                    if (out_hs && mode_q) begin
                        blk_cnt_q <= blk_end ? '0 : blk_cnt_q + BLK_W'(1);
                    end
                    if (job_end) begin
                        state_q   <= IDLE;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        blk_cnt_q <= '0;
                        done_q    <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign z_ready_o     = in_ready;
    assign busy_o        = (state_q == RUN);
    assign done_o        = done_q;

    // The inactive side sees a zero data bus; encoder takes only the low lanes.
    assign z_raw_valid_o = buf_vld_q & ~mode_q;
    assign z_raw_data_o  = mode_q ? '0 : buf_data_q;
    assign z_raw_strb_o  = mode_q ? '0 : buf_strb_q;

    assign z_enc_valid_o = buf_vld_q & mode_q;
    assign z_enc_data_o  = mode_q ? buf_data_q[ENCW-1:0] : '0;
    assign z_enc_last_o  = z_enc_valid_o & (blk_end | job_last_beat);

endmodule

// File: tb/tb_redmule_mx_output_demux.sv
// Scoreboard bench for redmule_mx_output_demux: random beats, a job-level reference model and
// a negedge monitor that checks routing, data, block framing, done/busy and reset/clear behaviour.
module tb_redmule_mx_output_demux;

    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int BITW  = 16;
    localparam int LANES = 16;
    localparam int EW    = LANES * BITW;
    localparam int BB    = 2;
    localparam int CW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni, clear_i, start_i, mx_enable_i;
    logic [CW-1:0] tot_beats_i;
    logic          busy_o, done_o;
    logic          z_valid_i, z_ready_o;
    logic [DW-1:0] z_data_i;
    logic [SW-1:0] z_strb_i;
    logic          z_raw_valid_o, z_raw_ready_i;
    logic [DW-1:0] z_raw_data_o;
    logic [SW-1:0] z_raw_strb_o;
    logic          z_enc_valid_o, z_enc_ready_i, z_enc_last_o;
    logic [EW-1:0] z_enc_data_o;

    redmule_mx_output_demux #(
        .DATAW_ALIGN(DW), .BITW(BITW), .MX_NUM_LANES(LANES), .BLOCK_BEATS(BB), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .mx_enable_i(mx_enable_i), .tot_beats_i(tot_beats_i), .busy_o(busy_o), .done_o(done_o),
        .z_valid_i(z_valid_i), .z_ready_o(z_ready_o), .z_data_i(z_data_i), .z_strb_i(z_strb_i),
        .z_raw_valid_o(z_raw_valid_o), .z_raw_ready_i(z_raw_ready_i),
        .z_raw_data_o(z_raw_data_o), .z_raw_strb_o(z_raw_strb_o),
        .z_enc_valid_o(z_enc_valid_o), .z_enc_ready_i(z_enc_ready_i),
        .z_enc_data_o(z_enc_data_o), .z_enc_last_o(z_enc_last_o)
    );

    typedef struct {
        bit            mode;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        bit            last;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   rdy_pct = 100;

    // reference model state: one job at a time
    bit   m_active = 0, m_mode = 0;
    int   m_tot = 0, m_acc = 0, m_out = 0;
    bit   done_next = 0, vld_next = 0, clr_prev = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic new_beat();
        for (int i = 0; i < DW / 32; i++) z_data_i[i*32 +: 32] = $urandom;
        for (int i = 0; i < SW / 32; i++) z_strb_i[i*32 +: 32] = $urandom;
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            z_enc_ready_i = ($urandom_range(99) < rdy_pct);
            z_raw_ready_i = ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   pre_act, new_done, new_vld, clr_now, dn_rdy;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                chk("rst_busy", busy_o, 0);
                chk("rst_done", done_o, 0);
                chk("rst_zready", z_ready_o, 0);
                chk("rst_raw_valid", z_raw_valid_o, 0);
                chk("rst_enc_valid", z_enc_valid_o, 0);
                chk("rst_raw_data", z_raw_data_o, 0);
                chk("rst_raw_strb", z_raw_strb_o, 0);
                chk("rst_enc_data", z_enc_data_o, 0);
                chk("rst_enc_last", z_enc_last_o, 0);
                q.delete();
                m_active = 0; m_acc = 0; m_out = 0;
                done_next = 0; vld_next = 0; clr_prev = 0;
            end else begin
                pre_act  = m_active;
                new_done = 0; new_vld = 0; clr_now = 0;
                chk("busy", busy_o, m_active);
                chk("done", done_o, done_next);
                if (clr_prev) chk("clear_outputs_idle", z_raw_valid_o | z_enc_valid_o, 0);
                if (vld_next) chk("latency_1", m_mode ? z_enc_valid_o : z_raw_valid_o, 1);
                dn_rdy = m_mode ? z_enc_ready_i : z_raw_ready_i;
                if (!m_active || m_acc >= m_tot) chk("zready_blocked", z_ready_o, 0);
                else if (dn_rdy) chk("zready_throughput", z_ready_o, 1);

                if (z_raw_valid_o && z_enc_valid_o) chk("both_valid", 1, 0);
                if (z_enc_valid_o) chk("raw_bus_zero", {z_raw_strb_o, z_raw_data_o[DW-SW-1:0]}, 0);
                if (z_raw_valid_o) chk("enc_bus_zero", z_enc_data_o, 0);
                if (z_raw_valid_o || z_enc_valid_o) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = q[0];
                        chk("route_enc", z_enc_valid_o, e.mode);
                        if (e.mode) begin
                            chk("enc_data", z_enc_data_o, e.data[EW-1:0]);
                            chk("enc_last", z_enc_last_o, e.last);
                        end else begin
                            chk("raw_data", z_raw_data_o, e.data);
                            chk("raw_strb", z_raw_strb_o, e.strb);
                        end
                        if ((z_raw_valid_o && z_raw_ready_i) || (z_enc_valid_o && z_enc_ready_i)) begin
                            void'(q.pop_front());
                            m_out++;
                            if (m_out == m_tot) begin
                                m_active = 0;
                                new_done = 1;
                            end
                        end
                    end
                end

                if (z_valid_i && z_ready_o && pre_act && m_acc < m_tot) begin
                    e.mode = m_mode;
                    e.data = z_data_i;
                    e.strb = z_strb_i;
                    e.last = ((m_acc % BB) == BB - 1) || (m_acc == m_tot - 1);
                    q.push_back(e);
                    m_acc++;
                    new_vld = 1;
                end

                if (clear_i) begin
                    q.delete();
                    m_active = 0; m_acc = 0; m_out = 0;
                    new_done = 0; new_vld = 0; clr_now = 1;
                end else if (start_i && !pre_act) begin
                    if (tot_beats_i == 0) begin
                        new_done = 1;
                    end else begin
                        m_active = 1; m_mode = mx_enable_i;
                        m_tot = int'(tot_beats_i); m_acc = 0; m_out = 0;
                    end
                end
                done_next = new_done;
                vld_next  = new_vld;
                clr_prev  = clr_now;
            end
        end
    endtask

    task automatic drive_job(input bit mode, input int tot, input int vprob, input bit toggle,
                             input int restart_at, input int abort_at, input bit abort_rst,
                             input bit exp_done);
        int cyc = 0;
        bit hs, got_done = 0, aborted = 0;
        @(posedge clk); #1;
        start_i = 1; mx_enable_i = mode; tot_beats_i = CW'(tot);
        @(posedge clk); #1;
        start_i = 0; tot_beats_i = CW'($urandom);
        new_beat();
        z_valid_i = ($urandom_range(99) < vprob);
        while (!got_done && !aborted && cyc < 3000) begin
            @(negedge clk);
            hs = z_valid_i && z_ready_o;
            if (done_o) got_done = 1;
            @(posedge clk); #1;
            cyc++;
            start_i = (cyc == restart_at);
            if (start_i) begin
                tot_beats_i = 7;
                mx_enable_i = ~mode;
            end
            if (toggle) mx_enable_i = 1'($urandom_range(1));
            if (cyc == abort_at) begin
                aborted = 1;
                z_valid_i = 0;
                start_i = 0;
                if (abort_rst) begin
                    rst_ni = 0;
                    @(negedge clk);
                    @(posedge clk); #1;
                    rst_ni = 1;
                end else begin
                    clear_i = 1;
                    @(posedge clk); #1;
                    clear_i = 0;
                end
            end else if (hs || !z_valid_i) begin
                new_beat();
                z_valid_i = ($urandom_range(99) < vprob);
            end
        end
        z_valid_i = 0;
        start_i = 0;
        chk("job_done_seen", got_done, exp_done);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
    endtask

    initial begin
        rst_ni = 0; clear_i = 0; start_i = 0; mx_enable_i = 0; tot_beats_i = '0;
        z_valid_i = 0; z_data_i = '0; z_strb_i = '0;
        z_enc_ready_i = 1; z_raw_ready_i = 1;
        fork
            ready_drv();
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 rst_ni = 1;

        rdy_pct = 100;
        drive_job(0, 4, 100, 0, 0, 0, 0, 1);   // bypass, 4 beats
        drive_job(1, 5, 100, 0, 0, 0, 0, 1);   // MX, last on beats 2,4,5
        drive_job(1, 9, 60, 0, 0, 0, 0, 1);    // input gaps, odd tail block

        rdy_pct = 70;
        drive_job(1, 40, 90, 0, 0, 0, 0, 1);   // encoder backpressure
        drive_job(0, 30, 90, 0, 0, 0, 0, 1);   // bypass backpressure

        drive_job(0, 12, 100, 1, 0, 0, 0, 1);  // mx_enable toggling mid-job
        drive_job(1, 12, 100, 1, 0, 0, 0, 1);

        rdy_pct = 100;
        drive_job(1, 0, 100, 0, 0, 0, 0, 1);   // empty job
        drive_job(0, 8, 100, 0, 2, 0, 0, 1);   // start while busy ignored

        rdy_pct = 0;
        drive_job(1, 6, 100, 0, 0, 4, 0, 0);   // clear with buffer full
        rdy_pct = 100;
        drive_job(1, 3, 100, 0, 0, 0, 0, 1);
        rdy_pct = 0;
        drive_job(0, 6, 100, 0, 0, 4, 1, 0);   // async reset with buffer full
        rdy_pct = 100;
        drive_job(0, 5, 100, 0, 0, 0, 0, 1);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
